fpu_add_seq: RTL
================

Name: fpu_add_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder/subtractor in the FPU execute path.
- The CPU's decode/execute stage issues add.s/sub.s operands from the FP register file into this block.
- It returns the rounded result and flags through a valid/ready handshake; the CPU writeback mux consumes the result.
- One operation in flight; fixed 4-cycle compute latency plus output backpressure.

Parameters:
- ROUND_NEAREST, 1, 1 = round-to-nearest-even; 0 = truncate (round toward zero).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block can accept (high only in IDLE).
- op_sub  in  1  0 = a+b, 1 = a-b (sign of b inverted at capture).
- a  in  32  operand A, IEEE-754 single.
- b  in  32  operand B, IEEE-754 single.
- out_valid  out  1  result valid (held until accepted).
- out_ready  in  1  consumer accepts result.
- result  out  32  IEEE-754 single result.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; in_ready=1; out_valid=0; result=32'h0; flags=4'h0. Asserting reset mid-operation aborts it immediately; no result is emitted.
- States: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- Transitions:
  - IDLE: in_valid at edge k captures a, b, op_sub.
  - Each compute state advances on the next edge, so DONE is entered at edge k+4 and out_valid=1 from then on.
  - DONE: result and flags stay stable while out_ready=0.
  - Edge with out_ready=1 in DONE: IDLE, out_valid=0.
  - No new capture in the same cycle as the DONE handshake; the next capture is at the earliest edge after returning to IDLE.
- Unpack at capture:
  - exp==0 operands are flushed to signed zero (denormals unsupported).
  - Hidden 1 is prepended for normals.
  - NaN/Inf are detected here.
- ALIGN: swap so |A|>=|B|. Right-shift the smaller mantissa by the exponent difference into a 27-bit {1.mant, guard, round, sticky} field. Any shift >=27 leaves only sticky.
- ADD: equal signs add, otherwise subtract; 28-bit datapath with carry.
- NORM:
  - Carry-out: shift right 1, exp+1, OR-ing the shifted-out bit into sticky.
  - Otherwise: leading-zero count, then left shift and exp-=lzc.
  - Exact-zero difference gives +0 (sign 0).
- ROUND:
  - RNE: increment when G&(R|S|lsb); mantissa overflow from rounding renormalises (exp+1).
  - Truncate: drop G/R/S.
  - inexact = G|R|S before rounding.
- Overflow (exp>=255 after round): result = signed Inf, overflow=1, inexact=1.
- Underflow (exp<=0): result = signed zero, underflow=1, inexact=1.
- Specials (bypass arithmetic, still 4-cycle latency, flags otherwise 0):
  - Any NaN input gives 32'h7FC00000, invalid=1.
  - Inf + (-Inf) after op_sub applied gives 32'h7FC00000, invalid=1.
  - Inf + finite gives that Inf.
  - (+0)+(-0) gives +0; (-0)+(-0) gives -0.
- Inputs a/b/op_sub are ignored outside the IDLE capture edge.

Decomposition:
- Shared package fpu_pkg holds:
  - field widths (EXP_W=8, MAN_W=23, BIAS=127);
  - constants QNAN=32'h7FC00000 and POS_INF=32'h7F800000;
  - the state enum;
  - the flag bit indices.
- Sub-module fpu_lzc28: combinational leading-zero counter over 28 bits (5-bit count, all-zero indicator), reused later by fpu_mul_seq.

Test Plan:
- a=32'h3FC00000 (1.5), b=32'h40600000 (3.5), op_sub=0 -> result 32'h40A00000 (5.0), flags 0, out_valid exactly 4 edges after capture.
- a=32'h3F800000, b=32'h3F800000, op_sub=1 -> result 32'h00000000, flags 0.
- a=32'h3F800000, b=32'h33800000 (tie) -> 32'h3F800000, inexact=1; b=32'h33800001 -> 32'h3F800001, inexact=1; with ROUND_NEAREST=0 both -> 32'h3F800000.
- a=32'h7F7FFFFF, b=32'h7F7FFFFF -> 32'h7F800000, overflow=1 and inexact=1; a=32'h7F800000, b=32'hFF800000 -> 32'h7FC00000, invalid=1.
- Hold out_ready=0 for 3 cycles in DONE -> result/flags/out_valid stable, in_ready=0, a/b changes ignored; out_ready=1 -> IDLE next edge, next op accepted the following edge.
- Drop reset_n during the ADD state -> out_valid=0 and in_ready=1 immediately; after release a fresh 1.0+2.0 yields 32'h40400000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, special encodings,
// sequencer states and flag bit positions.
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // First biased exponent that no longer encodes a finite value.
    localparam logic signed [9:0] EXP_SAT = 10'(2 * BIAS + 1);

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;
endpackage

// File: rtl/fpu_lzc28.sv
// Combinational leading-zero counter over a 28-bit field.
module fpu_lzc28 (
    input  logic [27:0] i_data,
    output logic [4:0]  o_cnt,
    output logic        o_zero
);
    always_comb begin
        o_cnt  = 5'd28;
        o_zero = ~|i_data;
        // Ascending scan: the highest set bit is the last one to write the count.
        for (int i = 0; i < 28; i++) begin
            if (i_data[i]) o_cnt = 5'(27 - i);
        end
    end
endmodule

// File: rtl/fpu_add_seq.sv
// Multi-cycle single-precision add/sub: capture, align, add, normalise, round,
// then hold the result until the consumer accepts it.
module fpu_add_seq
    import fpu_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op_sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    state_t r_state, w_next;

    logic              r_sa, r_sb, r_sign, r_sub, r_zero;
    logic [EXP_W-1:0]  r_ea, r_eb;
    logic [MAN_W:0]    r_ma, r_mb;
    logic              r_special, r_spec_inv;
    logic [31:0]       r_spec_res;
    logic signed [9:0] r_exp;
    logic [26:0]       r_big, r_sml, r_man;
    logic [27:0]       r_sum;
    logic [31:0]       r_result;
    logic [3:0]        r_flags;

    logic [EXP_W-1:0] w_ea, w_eb, w_big_e, w_sml_e, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [MAN_W:0]   w_big_m, w_sml_m;
    logic             w_sb, w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_special, w_spec_inv, w_a_ge, w_sticky, w_allz;
    logic [31:0]      w_spec_res;
    logic [26:0]      w_sml_ext, w_shr, w_sml_al;
    logic [4:0]       w_lzc, w_shl_n;

    function automatic logic [35:0] round_pack(input logic sign, input logic signed [9:0] exp_in,
                                               input logic [26:0] man);
        logic              inc;
        logic [24:0]       mr;
        logic [22:0]       frac;
        logic signed [9:0] e;
        logic [3:0]        f;
        f   = '0;
        inc = ROUND_NEAREST ? (man[2] & (man[1] | man[0] | man[3])) : 1'b0;
        mr  = {1'b0, man[26:3]} + {24'd0, inc};
        e   = exp_in;
        if (mr[24]) begin
            e    = e + 10'sd1;
            frac = mr[23:1];
        end else begin
            frac = mr[22:0];
        end
        f[FLG_INX] = |man[2:0];
        if (e >= EXP_SAT) begin
            f[FLG_OVF] = 1'b1;
            f[FLG_INX] = 1'b1;
            return {f, sign, POS_INF[30:0]};
        end
        if (e <= 10'sd0) begin
            f[FLG_UNF] = 1'b1;
            f[FLG_INX] = 1'b1;
            return {f, sign, 31'd0};
        end
        return {f, sign, e[7:0], frac};
    endfunction

    assign w_ea     = a[30:23];
    assign w_fa     = a[22:0];
    assign w_eb     = b[30:23];
    assign w_fb     = b[22:0];
    assign w_sb     = b[31] ^ op_sub;
    assign w_a_zero = ~|w_ea;
    assign w_b_zero = ~|w_eb;
    assign w_a_nan  = (&w_ea) & (|w_fa);
    assign w_b_nan  = (&w_eb) & (|w_fb);
    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);

    always_comb begin
        w_special  = 1'b1;
        w_spec_inv = 1'b1;
        w_spec_res = QNAN;
        if (!(w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != w_sb)))) begin
            w_spec_inv = 1'b0;
            if (w_a_inf)                   w_spec_res = {a[31], POS_INF[30:0]};
            else if (w_b_inf)              w_spec_res = {w_sb, POS_INF[30:0]};
            else if (w_a_zero && w_b_zero) w_spec_res = {a[31] & w_sb, 31'd0};
            else                           w_special  = 1'b0;
        end
    end

    assign w_a_ge    = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_big_e   = w_a_ge ? r_ea : r_eb;
    assign w_big_m   = w_a_ge ? r_ma : r_mb;
    assign w_sml_e   = w_a_ge ? r_eb : r_ea;
    assign w_sml_m   = w_a_ge ? r_mb : r_ma;
    assign w_diff    = w_big_e - w_sml_e;
    assign w_sml_ext = {w_sml_m, 3'b000};

    always_comb begin
        w_shr    = w_sml_ext >> w_diff;
        w_sticky = |(w_sml_ext & ((27'd1 << w_diff) - 27'd1));
        if (w_diff >= 8'd27) w_sml_al = {26'd0, |w_sml_m};
        else                 w_sml_al = {w_shr[26:1], w_shr[0] | w_sticky};
    end

    fpu_lzc28 u_lzc (
        .i_data (r_sum),
        .o_cnt  (w_lzc),
        .o_zero (w_allz)
    );
    // The leading one must land at bit 26, one below the carry position.
    assign w_shl_n = w_lzc - 5'd1;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_ALIGN;
            end
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ROUND) begin
                if (r_special) begin
                    r_result <= r_spec_res;
                    r_flags  <= {3'b000, r_spec_inv} << FLG_INV;
                end else if (r_zero) begin
                    r_result <= '0;
                    r_flags  <= '0;
                end else begin
                    {r_flags, r_result} <= round_pack(r_sign, r_exp, r_man);
                end
            end
        end
    end

    // Datapath registers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (in_valid) begin
                r_sa       <= a[31];
                r_sb       <= w_sb;
                r_ea       <= w_a_zero ? '0 : w_ea;
                r_ma       <= w_a_zero ? '0 : {1'b1, w_fa};
                r_eb       <= w_b_zero ? '0 : w_eb;
                r_mb       <= w_b_zero ? '0 : {1'b1, w_fb};
                r_special  <= w_special;
                r_spec_inv <= w_spec_inv;
                r_spec_res <= w_spec_res;
            end
            S_ALIGN: begin
                r_sign <= w_a_ge ? r_sa : r_sb;
                r_sub  <= r_sa ^ r_sb;
                r_exp  <= $signed({2'b00, w_big_e});
                r_big  <= {w_big_m, 3'b000};
                r_sml  <= w_sml_al;
            end
            S_ADD: r_sum <= r_sub ? ({1'b0, r_big} - {1'b0, r_sml}) : ({1'b0, r_big} + {1'b0, r_sml});
            S_NORM: begin
                r_zero <= w_allz;
                if (r_sum[27]) begin
                    r_man <= {r_sum[27:2], r_sum[1] | r_sum[0]};
                    r_exp <= r_exp + 10'sd1;
                end else begin
                    r_man <= 27'(r_sum << w_shl_n);
                    r_exp <= r_exp - $signed({5'd0, w_shl_n});
                end
            end
            default: ;
        endcase
    end

    assign result = r_result;
    assign flags  = r_flags;
endmodule
